// File: rtl/prefix_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone adder.
// The pg_t pair is the prefix operator's element; the helpers size the pipeline.
package prefix_adder_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    // hi covers the more significant span, lo the adjacent less significant span
    function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
        pg_t res;
        res.g = hi.g | (hi.p & lo.g);
        res.p = hi.p & lo.p;
        return res;
    endfunction

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    function automatic int log2w(input int width);
        return $clog2(width);
    endfunction

    function automatic int num_prefix_stages(input int width, input int lvls_per_stg);
        return ceil_div(log2w(width), lvls_per_stg);
    endfunction

    function automatic int pipe_latency(input int width, input int lvls_per_stg);
        return num_prefix_stages(width, lvls_per_stg) + 2;
    endfunction

endpackage

// File: rtl/pipelined_prefix_adder_prefix_level.sv
// One combinational Kogge-Stone level: every bit at or above DIST absorbs the
// group DIST positions below it; lower bits already hold complete prefixes.
module prefix_level
    import prefix_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] g_nxt,
    output logic [WIDTH-1:0] p_nxt
);

    for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
        if (i < DIST) begin : gen_pass
            assign g_nxt[i] = g[i];
            assign p_nxt[i] = p[i];
        end else begin : gen_comb
            pg_t res;
            assign res      = pg_combine(pg_t'({g[i], p[i]}), pg_t'({g[i-DIST], p[i-DIST]}));
            assign g_nxt[i] = res.g;
            assign p_nxt[i] = res.p;
        end
    end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake, flush and tag.
// One global advance enable moves every stage; there are no per-stage skid buffers.
module pipelined_prefix_adder
    import prefix_adder_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int LVLS_PER_STG = 1,
    parameter int TAG_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LOG2W = log2w(WIDTH);
    localparam int NPS   = num_prefix_stages(WIDTH, LVLS_PER_STG);

    // Index 0 is the operand-prep stage; index s holds the result of prefix stage s.
    logic [WIDTH-1:0] g_pk   [NPS+1];
    logic [WIDTH-1:0] p_pk   [NPS+1];
    logic [WIDTH-1:0] p1_pk  [NPS+1];
    logic             c0_pk  [NPS+1];
    logic [TAG_W-1:0] tag_pk [NPS+1];
    logic             vld_pk [NPS+1];

    logic [WIDTH-1:0] g_nx [1:NPS];
    logic [WIDTH-1:0] p_nx [1:NPS];

    logic             adv;
    logic [WIDTH-1:0] b_mod;
    logic             c0_mod;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_nx;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv & ~flush;

    // Subtraction is A + ~B + ~borrow, so the adder core only ever adds.
    assign b_mod  = in_sub ? ~in_b : in_b;
    assign c0_mod = in_sub ? ~in_ci : in_ci;

    // Prefix stages: each evaluates LVLS_PER_STG levels; levels beyond LOG2W pass through.
    for (genvar s = 1; s <= NPS; s++) begin : gen_stage
        logic [WIDTH-1:0] lvl_g [LVLS_PER_STG+1];
        logic [WIDTH-1:0] lvl_p [LVLS_PER_STG+1];

        assign lvl_g[0] = g_pk[s-1];
        assign lvl_p[0] = p_pk[s-1];

        for (genvar j = 0; j < LVLS_PER_STG; j++) begin : gen_lvl
            localparam int K = (s - 1) * LVLS_PER_STG + j + 1;
            if (K <= LOG2W) begin : gen_active
                prefix_level #(
                    .WIDTH (WIDTH),
                    .DIST  (1 << (K - 1))
                ) u_level (
                    .g     (lvl_g[j]),
                    .p     (lvl_p[j]),
                    .g_nxt (lvl_g[j+1]),
                    .p_nxt (lvl_p[j+1])
                );
            end else begin : gen_idle
                assign lvl_g[j+1] = lvl_g[j];
                assign lvl_p[j+1] = lvl_p[j];
            end
        end

        assign g_nx[s] = lvl_g[LVLS_PER_STG];
        assign p_nx[s] = lvl_p[LVLS_PER_STG];
    end

    // Output stage: G/P now span bit 0 upward, so each carry needs only c0.
    always_comb begin
        carry[0] = c0_pk[NPS];
        for (int i = 1; i <= WIDTH; i++) begin
            carry[i] = g_pk[NPS][i-1] | (p_pk[NPS][i-1] & c0_pk[NPS]);
        end
        sum_nx = p1_pk[NPS] ^ carry[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s <= NPS; s++) begin
                g_pk[s]   <= '0;
                p_pk[s]   <= '0;
                p1_pk[s]  <= '0;
                c0_pk[s]  <= 1'b0;
                tag_pk[s] <= '0;
                vld_pk[s] <= 1'b0;
            end
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_co    <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
            out_tag   <= '0;
        end else if (flush) begin
            for (int s = 0; s <= NPS; s++) begin
                vld_pk[s] <= 1'b0;
            end
            out_valid <= 1'b0;
        end else if (adv) begin
            vld_pk[0] <= in_valid;
            g_pk[0]   <= in_a & b_mod;
            p_pk[0]   <= in_a ^ b_mod;
            p1_pk[0]  <= in_a ^ b_mod;
            c0_pk[0]  <= c0_mod;
            tag_pk[0] <= in_tag;
            for (int s = 1; s <= NPS; s++) begin
                vld_pk[s] <= vld_pk[s-1];
                g_pk[s]   <= g_nx[s];
                p_pk[s]   <= p_nx[s];
                p1_pk[s]  <= p1_pk[s-1];
                c0_pk[s]  <= c0_pk[s-1];
                tag_pk[s] <= tag_pk[s-1];
            end
            out_valid <= vld_pk[NPS];
            out_sum   <= sum_nx;
            out_co    <= carry[WIDTH];
            out_ovf   <= carry[WIDTH] ^ carry[WIDTH-1];
            out_zero  <= ~|sum_nx;
            out_tag   <= tag_pk[NPS];
        end
    end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Bench for pipelined_prefix_adder: directed vector table, back-pressure stream,
// flush, mid-stream reset, and a width x levels-per-stage parameter sweep.
module tb_pipelined_prefix_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic        in_ci, in_sub;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_co, out_ovf, out_zero;
    logic [3:0]  out_tag;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pipelined_prefix_adder #(.WIDTH(32), .LVLS_PER_STG(1), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_ci(in_ci), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_co(out_co), .out_ovf(out_ovf), .out_zero(out_zero),
        .out_tag(out_tag)
    );

    // Parameter sweep instances, all driven by one shared operand stream
    logic [63:0] sw_a, sw_b;
    logic        sw_ci, sw_sub, sw_valid;
    logic [11:0] sw_ir, sw_ov;
    logic [63:0] sw_sum  [12];
    logic        sw_co   [12];
    logic        sw_ovf  [12];
    logic        sw_zero [12];
    logic [3:0]  sw_tag  [12];

    for (genvar wi = 0; wi < 4; wi++) begin : gen_w
        for (genvar li = 0; li < 3; li++) begin : gen_l
            localparam int W   = (wi == 0) ? 8 : (wi == 1) ? 13 : (wi == 2) ? 32 : 64;
            localparam int LG  = $clog2(W);
            localparam int L   = (li == 0) ? 1 : (li == 1) ? 2 : LG;
            localparam int IDX = wi * 3 + li;
            logic [W-1:0] s;
            logic         ir, ov, co, ovf, z;
            logic [3:0]   tg;
            pipelined_prefix_adder #(.WIDTH(W), .LVLS_PER_STG(L), .TAG_W(4)) u_sw (
                .clk(clk), .rst(rst), .flush(1'b0),
                .in_valid(sw_valid), .in_ready(ir),
                .in_a(sw_a[W-1:0]), .in_b(sw_b[W-1:0]), .in_ci(sw_ci), .in_sub(sw_sub),
                .in_tag(4'(IDX)),
                .out_valid(ov), .out_ready(1'b1),
                .out_sum(s), .out_co(co), .out_ovf(ovf), .out_zero(z), .out_tag(tg)
            );
            assign sw_ir[IDX]   = ir;
            assign sw_ov[IDX]   = ov;
            assign sw_sum[IDX]  = 64'(s);
            assign sw_co[IDX]   = co;
            assign sw_ovf[IDX]  = ovf;
            assign sw_zero[IDX] = z;
            assign sw_tag[IDX]  = tg;
        end
    end

    typedef struct {
        logic [31:0] a, b;
        logic        ci, sub;
        logic [3:0]  tag;
        logic [31:0] sum;
        logic        co, ovf, zero;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic        co, ovf, zero;
        logic [3:0]  tag;
    } res_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Arithmetic reference: plain A+B+ci / A-B-ci on wide integers, reduced to w bits
    function automatic void ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                      input logic ci, input logic sub,
                                      output logic [63:0] sum, output logic co,
                                      output logic ovf, output logic zero);
        logic [66:0]        ua, ub, ur, mask, cv;
        logic signed [66:0] sa, sb, sr, lim;
        mask = (67'd1 << w) - 67'd1;
        ua   = {3'b0, a} & mask;
        ub   = {3'b0, b} & mask;
        cv   = 67'(ci);
        sa   = $signed(ua);
        sb   = $signed(ub);
        if (ua[w-1]) sa = sa - $signed(67'd1 << w);
        if (ub[w-1]) sb = sb - $signed(67'd1 << w);
        if (!sub) begin
            ur = ua + ub + cv;
            co = ur[w];
            sr = sa + sb + $signed(cv);
        end else begin
            ur = ua - ub - cv;
            co = (ua >= ub + cv);
            sr = sa - sb - $signed(cv);
        end
        sum  = 64'(ur & mask);
        lim  = $signed(67'd1 << (w - 1));
        ovf  = (sr >= lim) || (sr < -lim);
        zero = (sum == 64'd0);
    endfunction

    function automatic int sw_width(input int idx);
        case (idx / 3)
            0: return 8;
            1: return 13;
            2: return 32;
            default: return 64;
        endcase
    endfunction

    function automatic int sw_latency(input int idx);
        int w, lg, l;
        w  = sw_width(idx);
        lg = $clog2(w);
        l  = (idx % 3 == 0) ? 1 : (idx % 3 == 1) ? 2 : lg;
        return (lg + l - 1) / l + 2;
    endfunction

    task automatic run_single(input logic [31:0] a, input logic [31:0] b, input logic ci,
                              input logic sub, input logic [3:0] tag, output int lat,
                              output res_t r);
        in_a = a; in_b = b; in_ci = ci; in_sub = sub; in_tag = tag; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        r.sum = out_sum; r.co = out_co; r.ovf = out_ovf; r.zero = out_zero; r.tag = out_tag;
    endtask

    function automatic res_t model32(input logic [31:0] a, input logic [31:0] b, input logic ci,
                                     input logic sub, input logic [3:0] tag);
        res_t        r;
        logic [63:0] s;
        ref_model(32, {32'b0, a}, {32'b0, b}, ci, sub, s, r.co, r.ovf, r.zero);
        r.sum = s[31:0];
        r.tag = tag;
        return r;
    endfunction

    vec_t vt[10];

    initial begin
        int   lat, got, sent, seen;
        res_t r, e, held;
        bit   stalled, accepted;
        res_t exp_q[$];
        logic [11:0] sw_seen;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_ci = 1'b0; in_sub = 1'b0; in_tag = '0;
        sw_a = '0; sw_b = '0; sw_ci = 1'b0; sw_sub = 1'b0; sw_valid = 1'b0;

        vt[0] = '{32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0, 4'h1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vt[1] = '{32'd5,         32'd7,         1'b0, 1'b1, 4'h2, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vt[2] = '{32'h8000_0000, 32'd1,         1'b0, 1'b1, 4'h3, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vt[3] = '{32'd1,         32'd1,         1'b0, 1'b0, 4'h4, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
        vt[4] = '{32'h7FFF_FFFF, 32'd1,         1'b0, 1'b0, 4'h5, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vt[5] = '{32'd0,         32'd0,         1'b0, 1'b1, 4'h6, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vt[6] = '{32'd0,         32'd0,         1'b1, 1'b1, 4'h7, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vt[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'h8, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vt[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 4'h9, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        vt[9] = '{32'h1234_5678, 32'd0,         1'b1, 1'b0, 4'hA, 32'h1234_5679, 1'b0, 1'b0, 1'b0};

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum",   64'(out_sum),   64'd0);
        chk("rst_out_flags", 64'({out_co, out_ovf, out_zero}), 64'd0);
        chk("rst_out_tag",   64'(out_tag),   64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            run_single(vt[i].a, vt[i].b, vt[i].ci, vt[i].sub, vt[i].tag, lat, r);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd7);
            chk($sformatf("vec%0d_sum", i),  64'(r.sum),  64'(vt[i].sum));
            chk($sformatf("vec%0d_co", i),   64'(r.co),   64'(vt[i].co));
            chk($sformatf("vec%0d_ovf", i),  64'(r.ovf),  64'(vt[i].ovf));
            chk($sformatf("vec%0d_zero", i), 64'(r.zero), 64'(vt[i].zero));
            chk($sformatf("vec%0d_tag", i),  64'(r.tag),  64'(vt[i].tag));
        end
        @(posedge clk); #1;

        // Back-pressure stream
        sent = 0; got = 0; stalled = 1'b0; held = '{default: '0};
        for (int cyc = 0; cyc < 600 && got < 20; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (!in_valid && sent < 20 && $urandom_range(0, 3) != 0) begin
                in_a = $urandom; in_b = $urandom;
                in_ci = 1'($urandom_range(0, 1)); in_sub = 1'($urandom_range(0, 1));
                in_tag = 4'(sent);
                in_valid = 1'b1;
            end
            #1;
            if (stalled) begin
                chk("bp_stall_valid", 64'(out_valid), 64'd1);
                chk("bp_stall_data", {27'b0, out_sum, out_co, out_ovf, out_zero, out_tag},
                    {27'b0, held.sum, held.co, held.ovf, held.zero, held.tag});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("bp_unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("bp_sum", 64'(out_sum), 64'(e.sum));
                    chk("bp_flags", 64'({out_co, out_ovf, out_zero}), 64'({e.co, e.ovf, e.zero}));
                    chk("bp_tag", 64'(out_tag), 64'(e.tag));
                end
                got++;
            end
            stalled = out_valid && !out_ready;
            held.sum = out_sum; held.co = out_co; held.ovf = out_ovf;
            held.zero = out_zero; held.tag = out_tag;
            accepted = in_valid && in_ready;
            if (accepted) begin
                exp_q.push_back(model32(in_a, in_b, in_ci, in_sub, in_tag));
                sent++;
            end
            @(posedge clk); #1;
            if (accepted) in_valid = 1'b0;
        end
        chk("bp_result_count", 64'(got), 64'd20);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Flush with five beats in flight and a beat offered during the flush
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            in_a = $urandom; in_b = $urandom; in_ci = 1'b0; in_sub = 1'b0; in_tag = 4'(i);
            in_valid = 1'b1;
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        chk("flush_no_out_valid", 64'(seen), 64'd0);
        in_a = $urandom; in_b = $urandom;
        e = model32(in_a, in_b, 1'b1, 1'b1, 4'hC);
        run_single(in_a, in_b, 1'b1, 1'b1, 4'hC, lat, r);
        chk("post_flush_latency", 64'(lat), 64'd7);
        chk("post_flush_sum", 64'(r.sum), 64'(e.sum));
        chk("post_flush_tag", 64'(r.tag), 64'(e.tag));
        @(posedge clk); #1;

        // Reset while results are in flight
        for (int i = 0; i < 8; i++) begin
            in_a = $urandom; in_b = $urandom; in_ci = 1'b0; in_sub = 1'b0; in_tag = 4'(i);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("rst_mid_pre_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_out_sum", 64'(out_sum), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        chk("rst_mid_no_residual", 64'(seen), 64'd0);
        in_a = $urandom; in_b = $urandom;
        e = model32(in_a, in_b, 1'b0, 1'b0, 4'h5);
        run_single(in_a, in_b, 1'b0, 1'b0, 4'h5, lat, r);
        chk("post_rst_latency", 64'(lat), 64'd7);
        chk("post_rst_sum", 64'(r.sum), 64'(e.sum));
        @(posedge clk); #1;

        // Parameter sweep: random add/sub on every width/levels combination
        for (int n = 0; n < 15; n++) begin
            logic [63:0] es;
            logic        eco, eovf, ez;
            sw_a = {$urandom, $urandom}; sw_b = {$urandom, $urandom};
            if (n == 0) begin sw_a = '1; sw_b = 64'd1; end
            sw_ci = 1'($urandom_range(0, 1)); sw_sub = 1'($urandom_range(0, 1));
            sw_valid = 1'b1;
            #1;
            chk("sw_in_ready", 64'(sw_ir), 64'hFFF);
            @(posedge clk); #1;
            sw_valid = 1'b0;
            lat = 1;
            sw_seen = '0;
            while (sw_seen != 12'hFFF && lat < 20) begin
                for (int k = 0; k < 12; k++) begin
                    if (sw_ov[k] && !sw_seen[k]) begin
                        sw_seen[k] = 1'b1;
                        ref_model(sw_width(k), sw_a, sw_b, sw_ci, sw_sub, es, eco, eovf, ez);
                        chk($sformatf("sw%0d_latency", k), 64'(lat), 64'(sw_latency(k)));
                        chk($sformatf("sw%0d_sum", k), sw_sum[k], es);
                        chk($sformatf("sw%0d_flags", k), 64'({sw_co[k], sw_ovf[k], sw_zero[k]}),
                            64'({eco, eovf, ez}));
                        chk($sformatf("sw%0d_tag", k), 64'(sw_tag[k]), 64'(k));
                    end
                end
                @(posedge clk); #1;
                lat++;
            end
            chk("sw_all_results", 64'(sw_seen), 64'hFFF);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
